// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the non-stallable pipeline write-back with queued long-latency results.
// Optional WB_BYPASS_EN: a result arriving into an idle port with an empty queue is written at its handshake edge.
module wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    input  logic        lo_valid,
    output logic        lo_ready,
    input  logic        lo_mul,
    input  logic [4:0]  lo_waddr,
    input  logic [31:0] lo_wdata,
    input  logic [31:0] lo_hi,
    input  logic [31:0] lo_lo,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic        mul_we,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_req,
    input  logic [4:0]  chk_addr1,
    input  logic [4:0]  chk_addr2,
    output logic        pend1,
    output logic        pend2
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [4:0] HI_REG = 5'd31;
    localparam logic [4:0] LO_REG = 5'd30;

    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_nxt;
    logic [SW-1:0] starve, starve_nxt;

    // Mul entries pack {hi, lo}; normal entries keep the result in the low half.
    logic          q_mul   [DEPTH];
    logic [4:0]    q_waddr [DEPTH];
    logic [63:0]   q_data  [DEPTH];

    logic full, empty, push_hs, discard, push, pop, bypass;
    logic        we_nxt, mul_we_nxt;
    logic [4:0]  waddr_nxt;
    logic [31:0] wdata_nxt, hi_nxt, lo_nxt;

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v >= SW'(STARVE_MAX)) ? SW'(STARVE_MAX) : v + 1'b1;
    endfunction

    function automatic logic hits(input logic [4:0] a, input logic mul, input logic [4:0] wa);
        return (a != 5'd0) && (mul ? (a == HI_REG || a == LO_REG) : (a == wa));
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign lo_ready = !full;
    assign push_hs  = lo_valid && !full;
    assign discard  = push_hs && !lo_mul && (lo_waddr == 5'd0);
    assign pop      = !empty && !pipe_we;
`ifdef WB_BYPASS_EN
    assign bypass   = push_hs && !discard && empty && !pipe_we;
`else
    assign bypass   = 1'b0;
`endif
    assign push     = push_hs && !discard && !bypass;

    assign count_nxt  = count + CW'(push) - CW'(pop);
    // Only cycles where the pipeline blocks a waiting head count toward starvation.
    assign starve_nxt = (!empty && pipe_we) ? sat_inc(starve) : '0;

    always_comb begin
        we_nxt     = 1'b0;
        mul_we_nxt = 1'b0;
        waddr_nxt  = waddr;
        wdata_nxt  = wdata;
        hi_nxt     = hi;
        lo_nxt     = lo;
        if (pipe_we) begin
            we_nxt    = 1'b1;
            waddr_nxt = pipe_waddr;
            wdata_nxt = pipe_wdata;
        end else if (pop) begin
            if (q_mul[rd_ptr]) begin
                mul_we_nxt = 1'b1;
                hi_nxt     = q_data[rd_ptr][63:32];
                lo_nxt     = q_data[rd_ptr][31:0];
            end else begin
                we_nxt    = 1'b1;
                waddr_nxt = q_waddr[rd_ptr];
                wdata_nxt = q_data[rd_ptr][31:0];
            end
        end else if (bypass) begin
            if (lo_mul) begin
                mul_we_nxt = 1'b1;
                hi_nxt     = lo_hi;
                lo_nxt     = lo_lo;
            end else begin
                we_nxt    = 1'b1;
                waddr_nxt = lo_waddr;
                wdata_nxt = lo_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            mul_we    <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            stall_req <= 1'b0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            starve    <= '0;
        end else begin
            we        <= we_nxt;
            waddr     <= waddr_nxt;
            wdata     <= wdata_nxt;
            mul_we    <= mul_we_nxt;
            hi        <= hi_nxt;
            lo        <= lo_nxt;
            stall_req <= (starve_nxt == SW'(STARVE_MAX)) || (count_nxt == CW'(DEPTH));
            count     <= count_nxt;
            starve    <= starve_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Queue storage needs no reset: validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_mul[wr_ptr]   <= lo_mul;
            q_waddr[wr_ptr] <= lo_waddr;
            q_data[wr_ptr]  <= lo_mul ? {lo_hi, lo_lo} : {32'd0, lo_wdata};
        end
    end

    always_comb begin
        logic [PW-1:0] offs;
        pend1 = (we && hits(chk_addr1, 1'b0, waddr)) || (mul_we && hits(chk_addr1, 1'b1, 5'd0));
        pend2 = (we && hits(chk_addr2, 1'b0, waddr)) || (mul_we && hits(chk_addr2, 1'b1, 5'd0));
        for (int i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - rd_ptr;
            if ({1'b0, offs} < count) begin
                if (hits(chk_addr1, q_mul[i], q_waddr[i])) pend1 = 1'b1;
                if (hits(chk_addr2, q_mul[i], q_waddr[i])) pend2 = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (DEPTH=4, STARVE_MAX=8).
module tb_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int SMAX  = 8;

    logic clk = 1'b0;
    logic rst;
    logic pipe_we, lo_valid, lo_ready, lo_mul, we, mul_we, stall_req, pend1, pend2;
    logic [4:0]  pipe_waddr, lo_waddr, waddr, chk_addr1, chk_addr2;
    logic [31:0] pipe_wdata, lo_wdata, lo_hi, lo_lo, wdata, hi, lo;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .lo_valid(lo_valid), .lo_ready(lo_ready), .lo_mul(lo_mul),
        .lo_waddr(lo_waddr), .lo_wdata(lo_wdata), .lo_hi(lo_hi), .lo_lo(lo_lo),
        .we(we), .waddr(waddr), .wdata(wdata),
        .mul_we(mul_we), .hi(hi), .lo(lo), .stall_req(stall_req),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .pend1(pend1), .pend2(pend2)
    );

    task automatic idle_inputs();
        pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
        lo_valid = 1'b0; lo_mul = 1'b0; lo_waddr = '0; lo_wdata = '0; lo_hi = '0; lo_lo = '0;
        chk_addr1 = '0; chk_addr2 = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_tests++; if (we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %0b want 0", we); end
        n_tests++; if (waddr !== 5'd0 || wdata !== 32'd0) begin n_fail++; $display("FAIL rst_wport got %0d/%0h want 0/0", waddr, wdata); end
        n_tests++; if (mul_we !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL rst_mulport got %0b/%0h/%0h want 0/0/0", mul_we, hi, lo); end
        n_tests++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %0b want 0", stall_req); end
        n_tests++; if (lo_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %0b want 1", lo_ready); end
        n_tests++; if (pend1 !== 1'b0 || pend2 !== 1'b0) begin n_fail++; $display("FAIL rst_pend got %0b%0b want 00", pend1, pend2); end
    endtask

    task automatic test_pipe_write();
        pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'h1234; chk_addr1 = 5'd5;
        tick();
        pipe_we = 1'b0;
        n_tests++; if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'h1234) begin n_fail++; $display("FAIL pipe_write got %0b/%0d/%0h want 1/5/1234", we, waddr, wdata); end
        n_tests++; if (mul_we !== 1'b0) begin n_fail++; $display("FAIL pipe_mulwe got %0b want 0", mul_we); end
        n_tests++; if (pend1 !== 1'b1) begin n_fail++; $display("FAIL pipe_pend got %0b want 1", pend1); end
        tick();
        n_tests++; if (we !== 1'b0 || waddr !== 5'd5 || wdata !== 32'h1234) begin n_fail++; $display("FAIL idle_hold got %0b/%0d/%0h want 0/5/1234", we, waddr, wdata); end
    endtask

    task automatic test_mul_push();
        lo_valid = 1'b1; lo_mul = 1'b1; lo_hi = 32'hAAAA0000; lo_lo = 32'h0000BBBB;
        chk_addr1 = 5'd31; chk_addr2 = 5'd30;
        n_tests++; if (lo_ready !== 1'b1) begin n_fail++; $display("FAIL mul_ready got %0b want 1", lo_ready); end
        tick();
        lo_valid = 1'b0; lo_mul = 1'b0;
`ifndef WB_BYPASS_EN
        n_tests++; if (mul_we !== 1'b0) begin n_fail++; $display("FAIL mul_early got %0b want 0", mul_we); end
        n_tests++; if (pend1 !== 1'b1 || pend2 !== 1'b1) begin n_fail++; $display("FAIL mul_pend_q got %0b%0b want 11", pend1, pend2); end
        tick();
`endif
        n_tests++; if (mul_we !== 1'b1 || hi !== 32'hAAAA0000 || lo !== 32'h0000BBBB) begin n_fail++; $display("FAIL mul_write got %0b/%0h/%0h want 1/aaaa0000/0000bbbb", mul_we, hi, lo); end
        n_tests++; if (we !== 1'b0) begin n_fail++; $display("FAIL mul_we0 got %0b want 0", we); end
        n_tests++; if (pend1 !== 1'b1) begin n_fail++; $display("FAIL mul_pend_out got %0b want 1", pend1); end
        tick();
        n_tests++; if (mul_we !== 1'b0 || pend1 !== 1'b0 || hi !== 32'hAAAA0000) begin n_fail++; $display("FAIL mul_after got %0b/%0b/%0h want 0/0/aaaa0000", mul_we, pend1, hi); end
        chk_addr1 = '0; chk_addr2 = '0;
    endtask

    task automatic test_zero_addr();
        // Pipeline busy so any stored entry would stay visible in the queue.
        pipe_we = 1'b1; pipe_waddr = 5'd2; pipe_wdata = 32'h2;
        lo_valid = 1'b1; lo_mul = 1'b0; lo_waddr = 5'd0; lo_wdata = 32'hDEAD;
        tick();
        lo_valid = 1'b0;
        n_tests++; if (pend1 !== 1'b0 || pend2 !== 1'b0) begin n_fail++; $display("FAIL zero_pend got %0b%0b want 00", pend1, pend2); end
        for (int i = 0; i < 3; i++) begin
            lo_valid = 1'b1; lo_waddr = 5'(20 + i); lo_wdata = 32'h200 + i;
            tick();
        end
        lo_valid = 1'b0;
        n_tests++; if (lo_ready !== 1'b1) begin n_fail++; $display("FAIL zero_count got ready=%0b want 1", lo_ready); end
        pipe_we = 1'b0;
        tick();
        n_tests++; if (we !== 1'b1 || waddr !== 5'd20 || wdata !== 32'h200) begin n_fail++; $display("FAIL zero_head got %0b/%0d/%0h want 1/20/200", we, waddr, wdata); end
        tick(); tick(); tick();
        n_tests++; if (we !== 1'b0) begin n_fail++; $display("FAIL zero_drain got %0b want 0", we); end
    endtask

    task automatic test_fill_drain();
        pipe_we = 1'b1; pipe_waddr = 5'd1; pipe_wdata = 32'h77; chk_addr1 = 5'd12;
        for (int i = 0; i < DEPTH; i++) begin
            lo_valid = 1'b1; lo_mul = 1'b0; lo_waddr = 5'(10 + i); lo_wdata = 32'h100 + i;
            tick();
        end
        n_tests++; if (lo_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %0b want 0", lo_ready); end
        n_tests++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL full_stall got %0b want 1", stall_req); end
        n_tests++; if (we !== 1'b1 || waddr !== 5'd1) begin n_fail++; $display("FAIL full_pipe got %0b/%0d want 1/1", we, waddr); end
        n_tests++; if (pend1 !== 1'b1) begin n_fail++; $display("FAIL full_pend got %0b want 1", pend1); end
        pipe_we = 1'b0; lo_waddr = 5'd25; lo_wdata = 32'hBAD;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            lo_valid = 1'b0;
            n_tests++; if (we !== 1'b1 || waddr !== 5'(10 + i) || wdata !== 32'h100 + i) begin n_fail++; $display("FAIL drain%0d got %0b/%0d/%0h want 1/%0d/%0h", i, we, waddr, wdata, 10 + i, 32'h100 + i); end
            n_tests++; if (lo_ready !== 1'b1 || stall_req !== 1'b0) begin n_fail++; $display("FAIL drain_ctl%0d got %0b/%0b want 1/0", i, lo_ready, stall_req); end
        end
        tick();
        n_tests++; if (we !== 1'b0 || pend1 !== 1'b0) begin n_fail++; $display("FAIL drain_end got %0b/%0b want 0/0", we, pend1); end
        chk_addr1 = '0;
    endtask

    task automatic test_starve();
        pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h33;
        lo_valid = 1'b1; lo_mul = 1'b0; lo_waddr = 5'd9; lo_wdata = 32'h99; chk_addr2 = 5'd9;
        tick();
        lo_valid = 1'b0;
        for (int k = 1; k <= SMAX; k++) begin
            tick();
            if (k == SMAX - 1) begin
                n_tests++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL starve_early got %0b want 0", stall_req); end
            end
        end
        n_tests++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL starve_stall got %0b want 1", stall_req); end
        n_tests++; if (we !== 1'b1 || waddr !== 5'd3 || pend2 !== 1'b1) begin n_fail++; $display("FAIL starve_pipe got %0b/%0d/%0b want 1/3/1", we, waddr, pend2); end
        pipe_we = 1'b0;
        tick();
        n_tests++; if (we !== 1'b1 || waddr !== 5'd9 || wdata !== 32'h99) begin n_fail++; $display("FAIL starve_pop got %0b/%0d/%0h want 1/9/99", we, waddr, wdata); end
        n_tests++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL starve_clear got %0b want 0", stall_req); end
        tick();
        chk_addr2 = '0;
    endtask

    task automatic test_reset_midop();
        pipe_we = 1'b1; pipe_waddr = 5'd4; pipe_wdata = 32'h44; chk_addr1 = 5'd14;
        for (int i = 0; i < 2; i++) begin
            lo_valid = 1'b1; lo_mul = 1'b0; lo_waddr = 5'(14 + i); lo_wdata = 32'hE0 + i;
            tick();
        end
        lo_valid = 1'b0;
        n_tests++; if (pend1 !== 1'b1) begin n_fail++; $display("FAIL mid_pend got %0b want 1", pend1); end
        #2 rst = 1'b0;
        #1;
        test_reset();
        idle_inputs();
        chk_addr1 = 5'd14;
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (we !== 1'b0 || mul_we !== 1'b0 || pend1 !== 1'b0) begin n_fail++; $display("FAIL stale%0d got %0b/%0b/%0b want 0/0/0", i, we, mul_we, pend1); end
        end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        #3;
        test_reset();
        tick();
        @(negedge clk) rst = 1'b1;
        tick();
        test_pipe_write();
        test_mul_push();
        test_zero_addr();
        test_fill_drain();
        test_starve();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter that owns the single general-register write port and the hi/lo write port of the register file. Merges the in-order pipeline write-back, which cannot be back-pressured, with results from long-latency units (multiplier, divider), which use a valid/ready handshake. Long-latency results queue in a small FIFO and drain in cycles with no pipeline write. Exposes pending-write lookups so decode can detect hazards on queued results.

## Interface
- DEPTH, 4, FIFO entries for long-latency results (power of two, ≥2)
- STARVE_MAX, 8, consecutive blocked cycles before a drain stall is requested (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- pipe_we  in  1  pipeline write-back valid
- pipe_waddr  in  5  pipeline destination register
- pipe_wdata  in  32  pipeline result
- lo_valid  in  1  long-op result valid
- lo_ready  out  1  FIFO can accept; equals !full
- lo_mul  in  1  entry is a hi/lo pair write
- lo_waddr  in  5  destination register (ignored when lo_mul=1)
- lo_wdata  in  32  result (ignored when lo_mul=1)
- lo_hi, lo_lo  in  32 each  hi/lo result (used when lo_mul=1)
- we, waddr, wdata  out  1/5/32  regfile write port, registered
- mul_we, hi, lo  out  1/32/32  regfile hi/lo port, registered
- stall_req  out  1  registered; pipeline must drive pipe_we=0 while it is 1
- chk_addr1, chk_addr2  in  5 each  decode read addresses
- pend1, pend2  out  1 each  combinational: a queued or in-flight write targets chk_addrN

## Operation
- Per cycle, exactly one source drives the output registers at the next edge. Priority: pipe_we=1 first, then FIFO head, else idle.
- Pipeline grant: we←1, waddr/wdata←pipe_*, mul_we←0.
- FIFO pop of a normal entry: we←1, mul_we←0. FIFO pop of a mul entry: mul_we←1, hi/lo←entry, we←0.
- Idle: we←0, mul_we←0. waddr, wdata, hi and lo hold their previous values.
- Push occurs on lo_valid & lo_ready. A non-mul entry with lo_waddr=0 is accepted and discarded: not stored, no write produced.
- Push and pop in the same cycle are both performed; count is unchanged.
- Starvation counter increments each cycle in which the FIFO is non-empty and pipe_we blocks the pop. It clears on any pop or when the FIFO is empty.
- When the counter reaches STARVE_MAX, stall_req←1. The head pops in the next cycle, which the protocol guarantees has pipe_we=0. stall_req and the counter then clear.
- The FIFO-full condition also sets stall_req, with the same drain behaviour.
- pipe_we=1 while stall_req=1 is a protocol violation. The pipeline write wins and the counter saturates.
- pendN=1 when chk_addrN≠0 and it matches any of:
  - the waddr of a valid non-mul FIFO entry;
  - address 30 or 31 for a valid mul entry;
  - the output registers with we=1 (waddr) or mul_we=1 (30/31).
- Register 31 receives hi and register 30 receives lo. The regfile applies both in the same edge.

## Timing
- Reset (rst=0, asynchronous) forces:
  - we=0, waddr=0, wdata=0;
  - mul_we=0, hi=0, lo=0;
  - stall_req=0;
  - FIFO empty, starvation counter 0.
- While in reset, lo_ready=1 and pend1=pend2=0. Reset mid-operation discards all queued entries.
- Pipeline latency: pipe_we sampled at edge N gives we=1 visible after edge N.
- Long-op latency, FIFO empty and no pipe_we: push at edge N, pop at edge N+1, write visible after N+1.
- Full: lo_ready=0, and no push occurs in that cycle even if a pop frees a slot. lo_ready rises the cycle after the pop.
- Pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1.

## Configuration
- WB_BYPASS_EN defined: when the FIFO is empty, pipe_we=0 and a push handshakes, the entry goes directly to the output registers at that edge (latency 0 after the handshake edge) and is not stored. Zero-address discard still applies.
- WB_BYPASS_EN undefined: every long-op result passes through the FIFO, giving minimum latency of one extra cycle.

## Test plan
- Reset with pending entries → all outputs 0 and lo_ready=1 immediately. After release, no stale writes appear.
- pipe_we=1, waddr=5, wdata=0x1234 → after the next edge: we=1, waddr=5, wdata=0x1234, mul_we=0.
- Push mul entry (hi=0xAAAA0000, lo=0x0000BBBB) on an idle port → mul_we=1 with those values one edge later (zero edges later with WB_BYPASS_EN). pend1=1 for chk_addr1=31 until then.
- Push 4 entries while pipe_we=1 continuously → lo_ready=0 and stall_req=1. With pipe_we dropped, entries retire in order over 4 cycles and lo_ready returns to 1.
- One entry queued, pipe_we=1 for STARVE_MAX cycles → stall_req=1 on the next cycle, head retires, then stall_req=0.
- Push non-mul entry with lo_waddr=0 → no we pulse, FIFO count unchanged, pend stays 0.
